// File: rtl/input_buffer_sequencer.sv
// Input-activation buffer sequencer for one CNN layer pass.
// Each row runs clear, a 1- or 2-beat parallel load, then kx compute taps separated by dilation shifts.
module input_buffer_sequencer #(
  parameter int MAXIMUM_DILATION_BITS = 3,
  parameter int KX_BITS               = 3,
  parameter int ROW_BITS              = 10
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic                             start_i,
  input  logic [KX_BITS-1:0]               cfg_kx_i,
  input  logic [MAXIMUM_DILATION_BITS-1:0] cfg_dilation_i,
  input  logic [ROW_BITS-1:0]              cfg_rows_i,
  input  logic                             cfg_strided_i,
  input  logic                             cfg_deconv_i,
  input  logic                             par_valid_i,
  output logic                             par_ready_o,
  input  logic                             ser_valid_i,
  output logic                             ser_ready_o,
  input  logic                             mac_stall_i,
  output logic                             clear_o,
  output logic                             loading_in_parallel_o,
  output logic                             enable_o,
  output logic [MAXIMUM_DILATION_BITS-1:0] shift_input_buffer_o,
  output logic [1:0]                       cr_fifo_o,
  output logic                             enable_strided_conv_o,
  output logic                             enable_deconv_o,
  output logic                             mac_valid_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [3:0]                       state_o
);

  // Handshakes: a beat transfers on a cycle where valid and ready are both high;
  // ready is a pure function of state and mac_stall_i, never of valid.
  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_LD0, S_LD1, S_LWAIT, S_COMP, S_SHIFT, S_ROWEND, S_DONE
  } state_e;

  state_e                           state_q, state_d;
  logic [KX_BITS-1:0]               kx_q, kx_d, tap_q, tap_d;
  logic [MAXIMUM_DILATION_BITS-1:0] dil_q, dil_d;
  logic [ROW_BITS-1:0]              rows_q, rows_d, row_q, row_d;
  logic                             strided_q, strided_d, deconv_q, deconv_d;
  logic                             cr0_q, cr0_d;
  logic                             two_beat;
  logic                             ld_active, ld_val;

  assign two_beat = strided_q | deconv_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      kx_q      <= '0;
      dil_q     <= '0;
      rows_q    <= '0;
      strided_q <= 1'b0;
      deconv_q  <= 1'b0;
      tap_q     <= '0;
      row_q     <= '0;
      cr0_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      kx_q      <= kx_d;
      dil_q     <= dil_d;
      rows_q    <= rows_d;
      strided_q <= strided_d;
      deconv_q  <= deconv_d;
      tap_q     <= tap_d;
      row_q     <= row_d;
      cr0_q     <= cr0_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    kx_d                  = kx_q;
    dil_d                 = dil_q;
    rows_d                = rows_q;
    strided_d             = strided_q;
    deconv_d              = deconv_q;
    tap_d                 = tap_q;
    row_d                 = row_q;
    cr0_d                 = cr0_q;
    clear_o               = 1'b0;
    loading_in_parallel_o = 1'b0;
    enable_o              = 1'b0;
    mac_valid_o           = 1'b0;
    par_ready_o           = 1'b0;
    ser_ready_o           = 1'b0;
    done_o                = 1'b0;
    ld_active             = 1'b0;
    ld_val                = 1'b0;
    // A stalled array freezes everything: no state change, no strobe, no handshake.
    if (!mac_stall_i) begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            kx_d      = (cfg_kx_i == '0) ? KX_BITS'(1) : cfg_kx_i;
            dil_d     = (cfg_dilation_i == '0) ? MAXIMUM_DILATION_BITS'(1) : cfg_dilation_i;
            rows_d    = cfg_rows_i;
            strided_d = cfg_strided_i;
            deconv_d  = cfg_deconv_i & ~cfg_strided_i;
            row_d     = '0;
            tap_d     = '0;
            state_d   = (cfg_rows_i == '0) ? S_DONE : S_CLR;
          end
        end
        S_CLR: begin
          clear_o = 1'b1;
          tap_d   = '0;
          state_d = S_LD0;
        end
        S_LD0, S_LD1: begin
          par_ready_o = 1'b1;
          ld_active   = 1'b1;
          // First beat of a two-beat load fills the low half; a single beat fills everything.
          ld_val      = (state_q == S_LD1) | ~two_beat;
          if (par_valid_i) begin
            loading_in_parallel_o = 1'b1;
            cr0_d   = ld_val;
            state_d = (state_q == S_LD0 && two_beat) ? S_LD1 : S_LWAIT;
          end
        end
        S_LWAIT: state_d = S_COMP;
        S_COMP: begin
          mac_valid_o = 1'b1;
          state_d     = (tap_q == kx_q - KX_BITS'(1)) ? S_ROWEND : S_SHIFT;
        end
        S_SHIFT: begin
          ser_ready_o = 1'b1;
          enable_o    = ser_valid_i;
          if (ser_valid_i) begin
            tap_d   = tap_q + KX_BITS'(1);
            state_d = S_COMP;
          end
        end
        S_ROWEND: begin
          if (row_q == rows_q - ROW_BITS'(1)) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + ROW_BITS'(1);
            state_d = S_CLR;
          end
        end
        S_DONE: begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign shift_input_buffer_o  = (state_q == S_SHIFT) ? dil_q : '0;
  assign cr_fifo_o[1]          = two_beat & tap_q[0];
  assign cr_fifo_o[0]          = ld_active ? ld_val : cr0_q;
  assign enable_strided_conv_o = strided_q;
  assign enable_deconv_o       = deconv_q;
  assign busy_o                = (state_q != S_IDLE);
  assign state_o               = state_q;

endmodule

// File: tb/tb_input_buffer_sequencer.sv
// Bench for input_buffer_sequencer: an event-level model of each pass is queued at start and every
// strobe the DUT emits is matched against it, alongside per-cycle rules and hand-computed timings.
module tb_input_buffer_sequencer;

  localparam int MDB = 3;
  localparam int KXB = 3;
  localparam int RB  = 10;

  localparam logic [7:0] EV_CLR  = 8'h10;
  localparam logic [7:0] EV_LD   = 8'h20;
  localparam logic [7:0] EV_MAC  = 8'h30;
  localparam logic [7:0] EV_SH   = 8'h40;
  localparam logic [7:0] EV_DONE = 8'h50;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [KXB-1:0] cfg_kx = '0;
  logic [MDB-1:0] cfg_dil = '0;
  logic [RB-1:0]  cfg_rows = '0;
  logic           cfg_strided = 1'b0, cfg_deconv = 1'b0;
  logic           par_valid = 1'b0, ser_valid = 1'b0, mac_stall = 1'b0;
  logic           par_ready, ser_ready, clear, loading, enable, mac_valid, busy, done;
  logic           en_strided, en_deconv;
  logic [MDB-1:0] shift_amt;
  logic [1:0]     cr_fifo;
  logic [3:0]     state_dbg;

  input_buffer_sequencer #(.MAXIMUM_DILATION_BITS(MDB), .KX_BITS(KXB), .ROW_BITS(RB)) dut (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start),
    .cfg_kx_i(cfg_kx), .cfg_dilation_i(cfg_dil), .cfg_rows_i(cfg_rows),
    .cfg_strided_i(cfg_strided), .cfg_deconv_i(cfg_deconv),
    .par_valid_i(par_valid), .par_ready_o(par_ready),
    .ser_valid_i(ser_valid), .ser_ready_o(ser_ready),
    .mac_stall_i(mac_stall), .clear_o(clear), .loading_in_parallel_o(loading),
    .enable_o(enable), .shift_input_buffer_o(shift_amt), .cr_fifo_o(cr_fifo),
    .enable_strided_conv_o(en_strided), .enable_deconv_o(en_deconv),
    .mac_valid_o(mac_valid), .busy_o(busy), .done_o(done), .state_o(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int  tests = 0, failed = 0;
  bit  pass_active = 1'b0;
  bit  m_strided = 1'b0, m_deconv = 1'b0;
  int  start_cyc = 0;
  int  n_clr = 0, n_ld = 0, n_mac = 0, n_sh = 0, n_par_wait = 0, n_ser_wait = 0;
  int  b_clr, b_ld, b_mac, b_sh, b_pw, b_sw;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected strobe events for a whole pass, straight from the row/tap rules.
  task automatic build_model(input int kx, input int dil, input int rows, input bit str, input bit dec);
    int  k, d;
    bit  two;
    k   = (kx == 0) ? 1 : kx;
    d   = (dil == 0) ? 1 : dil;
    two = str | dec;
    for (int r = 0; r < rows; r++) begin
      exp_q.push_back(EV_CLR);
      if (two) begin
        exp_q.push_back(EV_LD | 8'h0);
        exp_q.push_back(EV_LD | 8'h1);
      end else begin
        exp_q.push_back(EV_LD | 8'h1);
      end
      for (int t = 0; t < k; t++) begin
        exp_q.push_back(EV_MAC | 8'(((two && (t % 2 == 1)) ? 2 : 0) + 1));
        if (t < k - 1) exp_q.push_back(EV_SH | 8'(d));
      end
    end
    exp_q.push_back(EV_DONE);
    m_strided = str;
    m_deconv  = dec & ~str;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int         ns;
    logic [7:0] ev;
    if (rst_n) begin
      ns = int'(clear) + int'(loading) + int'(enable) + int'(mac_valid) + int'(done);
      if (ns > 1) check("one_strobe_per_cycle", ns, 1);
      if (mac_stall) check("stall_quiet", int'({clear, loading, enable, mac_valid, par_ready, ser_ready}), 0);
      check("enable_needs_ser_valid", int'(enable & ~ser_valid), 0);
      check("load_needs_par_valid", int'(loading & ~par_valid), 0);
      check("busy", int'(busy), int'(pass_active));
      if (pass_active) begin
        check("mode_strided", int'(en_strided), int'(m_strided));
        check("mode_deconv", int'(en_deconv), int'(m_deconv));
      end
      if (par_ready && !par_valid && !mac_stall) n_par_wait++;
      if (ser_ready && !ser_valid && !mac_stall) n_ser_wait++;
      if (ns == 1) begin
        ev = clear     ? EV_CLR :
             loading   ? (EV_LD | 8'(cr_fifo)) :
             mac_valid ? (EV_MAC | 8'(cr_fifo)) :
             enable    ? (EV_SH | 8'(shift_amt)) : EV_DONE;
        if (clear) n_clr++;
        if (loading) n_ld++;
        if (mac_valid) n_mac++;
        if (enable) n_sh++;
        if (exp_q.size() == 0) check("unexpected_event", int'(ev), 0);
        else check("event", int'(ev), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int kx, input int dil, input int rows, input bit str, input bit dec);
    build_model(kx, dil, rows, str, dec);
    @(posedge clk); #1;
    cfg_kx = KXB'(kx); cfg_dil = MDB'(dil); cfg_rows = RB'(rows);
    cfg_strided = str; cfg_deconv = dec; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    pass_active = 1'b1;
    b_clr = n_clr; b_ld = n_ld; b_mac = n_mac; b_sh = n_sh; b_pw = n_par_wait; b_sw = n_ser_wait;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check({name, "_done_timeout"}, int'(n == 500), 0);
    check({name, "_done_latency"}, cyc - start_cyc + 1, exp_lat);
    @(posedge clk); #1;
    pass_active = 1'b0;
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_ready(input string name, input bit ser);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ser ? ser_ready : par_ready) break;
    end
    check({name, "_ready_timeout"}, int'(n == 200), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({clear, loading, enable, shift_amt, cr_fifo, en_strided, en_deconv,
                                 mac_valid, busy, done, par_ready, ser_ready}), 0);
    rst_n = 1'b1;
    par_valid = 1'b1; ser_valid = 1'b1;

    // Normal pass: two rows of three taps, dilation 1.
    do_start(3, 1, 2, 1'b0, 1'b0);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mac_valid) break;
    end
    check("t1_first_mac_latency", cyc - start_cyc + 1, 4);
    wait_done("t1", 19);
    check("t1_clears", n_clr - b_clr, 2);
    check("t1_loads", n_ld - b_ld, 2);
    check("t1_macs", n_mac - b_mac, 6);
    check("t1_shifts", n_sh - b_sh, 4);

    // Strided: two load beats, tap parity on cr_fifo[1], shift of 2.
    do_start(2, 2, 1, 1'b1, 1'b0);
    wait_done("t2", 9);
    check("t2_loads", n_ld - b_ld, 2);
    check("t2_shifts", n_sh - b_sh, 1);

    // Both modes requested: strided wins.
    do_start(2, 1, 1, 1'b1, 1'b1);
    wait_done("t2b", 9);

    // Deconv, kx=1, dilation 0 (no shifts ever).
    do_start(1, 0, 2, 1'b0, 1'b1);
    wait_done("t2c", 13);
    check("t2c_shifts", n_sh - b_sh, 0);
    check("t2c_loads", n_ld - b_ld, 4);

    // Handshake back-pressure: 5 idle cycles on each interface.
    par_valid = 1'b0; ser_valid = 1'b0;
    do_start(2, 3, 1, 1'b0, 1'b0);
    wait_ready("t3_par", 1'b0);
    repeat (5) @(posedge clk);
    #1 par_valid = 1'b1;
    wait_ready("t3_ser", 1'b1);
    repeat (5) @(posedge clk);
    #1 ser_valid = 1'b1;
    wait_done("t3", 18);
    check("t3_par_wait", n_par_wait - b_pw, 5);
    check("t3_ser_wait", n_ser_wait - b_sw, 5);
    check("t3_shifts", n_sh - b_sh, 1);
    check("t3_loads", n_ld - b_ld, 1);

    // Array stall for 3 cycles on the second COMP.
    do_start(3, 1, 1, 1'b0, 1'b0);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mac_valid) break;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    mac_stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 mac_stall = 1'b0;
    wait_done("t4", 13);
    check("t4_macs", n_mac - b_mac, 3);

    // Boundaries.
    do_start(2, 1, 0, 1'b0, 1'b0);
    wait_done("t5_rows0", 1);
    check("t5_rows0_clears", n_clr - b_clr, 0);

    do_start(0, 2, 1, 1'b0, 1'b0);
    wait_done("t5_kx0", 6);
    check("t5_kx0_shifts", n_sh - b_sh, 0);
    check("t5_kx0_macs", n_mac - b_mac, 1);

    do_start(2, 1, 1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    cfg_kx = 3'd5; cfg_rows = 10'd3; cfg_strided = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t5_busy_start", 8);
    check("t5_busy_start_clears", n_clr - b_clr, 1);
    repeat (4) @(negedge clk);

    // Reset while waiting in SHIFT, then a clean pass.
    ser_valid = 1'b0;
    do_start(3, 1, 1, 1'b0, 1'b0);
    wait_ready("t6_ser", 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", int'({clear, loading, enable, shift_amt, cr_fifo, en_strided, en_deconv,
                                    mac_valid, busy, done, par_ready, ser_ready}), 0);
    exp_q.delete();
    pass_active = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ser_valid = 1'b1;
    do_start(3, 1, 1, 1'b0, 1'b0);
    wait_done("t6_clean", 10);
    check("t6_macs", n_mac - b_mac, 3);
    check("t6_shifts", n_sh - b_sh, 2);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
